digit_serial_multiplier: RTL and testbench



---
 rtl/digit_serial_multiplier_if.sv | 25 ++
 rtl/digit_serial_multiplier.sv | 113 +++++++++++
 tb/tb_digit_serial_multiplier.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_multiplier_if.sv
// Handshake bus for the digit-serial multiplier. The slave side is the
// multiplier. The master side is the producer/consumer that drives it.
interface digit_serial_multiplier_if #(
  parameter int WIDTH = 12
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] c;
  logic               busy;

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, c, busy
  );

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, c, busy
  );
endinterface

// File: rtl/digit_serial_multiplier.sv
// Digit-serial WIDTH x WIDTH multiplier.
// Each cycle it consumes DIGIT bits of b, LSB digit first. It runs in
// unsigned or two's-complement mode. The product is modulo 2^(2*WIDTH).
// Instead of indexing by the digit counter, the multiplicand is kept
// pre-shifted and b is shifted down. This keeps every select constant.
module digit_serial_multiplier #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  digit_serial_multiplier_if.slave  bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("digit_serial_multiplier: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e           state_q, state_d;
  logic [W2-1:0]    a_sh_q;   // a_ext << (DIGIT*k)
  logic [WIDTH-1:0] b_sh_q;   // b >> (DIGIT*k); current digit in the low bits
  logic             bneg_q;   // signed mode with negative b: MSB weight is negative
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    c_q;

  logic             accept, rdy, last;
  logic [W2-1:0]    a_ext_in, pp, corr, acc_d;

  assign last = (cnt_q == CW'(N - 1));

  // Extend the incoming operand and compute the next accumulator value
  always_comb begin
    a_ext_in = bus.signed_mode ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a}
                               : {{WIDTH{1'b0}}, bus.a};
    pp       = a_sh_q * W2'(b_sh_q[DIGIT-1:0]);
    // On the last digit a_sh_q = a_ext << (WIDTH-DIGIT), so one more
    // DIGIT shift gives a_ext << WIDTH.
    corr     = (last && bneg_q) ? (a_sh_q << DIGIT) : '0;
    acc_d    = acc_q + pp - corr;
  end

  // FSM next state and handshake decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rdy     = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        rdy = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand latch, digit iteration and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      bneg_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      c_q    <= '0;
    end else if (accept) begin
      a_sh_q <= a_ext_in;
      b_sh_q <= bus.b;
      bneg_q <= bus.signed_mode & bus.b[WIDTH-1];
      cnt_q  <= '0;
      acc_q  <= '0;
    end else if (state_q == COMPUTE) begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_q << DIGIT;
      b_sh_q <= b_sh_q >> DIGIT;
      cnt_q  <= cnt_q + 1'b1;
      if (last) c_q <= acc_d;
    end
  end

  assign bus.in_ready  = rst_n & rdy;
  assign bus.busy      = (state_q == COMPUTE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.c         = c_q;
endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Scoreboard bench for digit_serial_multiplier (WIDTH=12, DIGIT=3).
// The driver pushes expected products and accept cycles into queues.
// The monitor pops them when an output handshake or a rising out_valid appears.
module tb_digit_serial_multiplier;
  localparam int WIDTH = 12;
  localparam int DIGIT = 3;
  localparam int N     = WIDTH / DIGIT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digit_serial_multiplier_if #(.WIDTH(WIDTH)) bus();
  digit_serial_multiplier #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        sm;
    logic [23:0] e;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          last_acc;
  int          mon_t;
  logic        prev_ov = 1'b0;
  logic [23:0] exp_q[$];
  int          acc_cyc_q[$];
  vec_t        vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: check latency on rising out_valid and check the product on each output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_ov) begin
        if (acc_cyc_q.size() == 0) fail("unexpected_out_valid");
        else begin
          mon_t = acc_cyc_q.pop_front();
          chk("latency", cyc - mon_t, N);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_output");
        else chk("product", {8'h0, bus.c}, {8'h0, exp_q.pop_front()});
      end
    end
    prev_ov = bus.out_valid;
  end

  // Present operands and hold in_valid until accepted. The call is made from
  // posedge+1 and returns at posedge+1 of the accept edge.
  task automatic issue(input logic [11:0] av, input logic [11:0] bv,
                       input logic sm, input logic [23:0] e);
    int n = 0;
    bus.a = av; bus.b = bv; bus.signed_mode = sm; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin n++; @(negedge clk); end
    if (!bus.in_ready) fail("accept_timeout");
    else begin
      @(posedge clk); #1;
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc);
      last_acc = cyc;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    if (exp_q.size() != 0) fail("drain_timeout");
  endtask

  initial begin
    int t0;
    int n;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_c",         bus.c,         0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Unsigned max
    issue(12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
    bus.in_valid = 1'b0;
    chk("busy_in_compute", bus.busy, 1);
    drain();

    // Signed corners and zero/edge operands
    vecs.push_back('{12'hFFF, 12'hFFF, 1'b1, 24'h000001});
    vecs.push_back('{12'h800, 12'h800, 1'b1, 24'h400000});
    vecs.push_back('{12'h005, 12'hFFD, 1'b1, 24'hFFFFF1});
    vecs.push_back('{12'h7FF, 12'h800, 1'b1, 24'hC00800});
    vecs.push_back('{12'h800, 12'hFFF, 1'b1, 24'h000800});
    vecs.push_back('{12'hFFF, 12'h001, 1'b1, 24'hFFFFFF});
    vecs.push_back('{12'h000, 12'h5A5, 1'b0, 24'h000000});
    vecs.push_back('{12'hFFF, 12'h000, 1'b1, 24'h000000});
    vecs.push_back('{12'hFFF, 12'h800, 1'b0, 24'h7FF800});
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].e);
      bus.in_valid = 1'b0;
      drain();
    end

    // Backpressure: output held and new input ignored while out_ready=0
    bus.out_ready = 1'b0;
    issue(12'h123, 12'h456, 1'b0, 24'h04EDC2);
    bus.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin n++; @(negedge clk); end
    if (!bus.out_valid) fail("done_timeout");
    bus.a = 12'h001; bus.b = 12'h001; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_c",         bus.c,         24'h04EDC2);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready",  bus.in_ready,  0);
      chk("bp_busy",      bus.busy,      0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released_out_valid", bus.out_valid, 0);
    chk("bp_released_busy",      bus.busy,      0);
    chk("bp_c_kept",             bus.c,         24'h04EDC2);
    drain();

    // Back-to-back with in_valid held high
    issue(12'h003, 12'h007, 1'b0, 24'h000015);
    t0 = last_acc;
    issue(12'hABC, 12'h123, 1'b0, 24'h0C33B4);
    chk("b2b_spacing", last_acc - t0, N + 1);
    bus.in_valid = 1'b0;
    drain();

    // Reset in the 2nd COMPUTE cycle aborts the operation
    bus.a = 12'h7FF; bus.b = 12'h7FF; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_busy",      bus.busy,      0);
    chk("async_rst_in_ready",  bus.in_ready,  0);
    chk("async_rst_c",         bus.c,         0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    issue(12'h002, 12'h003, 1'b0, 24'h000006);
    bus.in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
endmodule
